cache_mem_arbiter: RTL
======================

Name: cache_mem_arbiter

Overview:
- Shares the single backing-memory port between the instruction-cache refill path and the data-cache refill/writeback path of the Riscv151 core.
- Each requester uses a valid/ready request and a one-cycle response pulse.
- The memory side is a valid/ready request channel with a variable-latency read response.
- At most one memory transaction is in flight. The dcache has priority, and a bounded anti-starvation rule protects the icache.

Parameters:
- ADDR_W, 32, request address width (byte address)
- DATA_W, 128, line/beat width of every transfer
- STARVE_LIMIT, 4, consecutive dcache grants while the icache waits before the icache is forced to win (1..15)

Ports:
- clk  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ic_req_valid  in  1  icache read request
- ic_req_ready  out  1  icache request accepted this cycle
- ic_req_addr  in  ADDR_W  icache read address
- ic_resp_valid  out  1  one-cycle pulse, read data valid
- ic_resp_data  out  DATA_W  icache read data
- dc_req_valid  in  1  dcache request
- dc_req_ready  out  1  dcache request accepted this cycle
- dc_req_rw  in  1  1 = write, 0 = read
- dc_req_addr  in  ADDR_W  dcache address
- dc_req_wdata  in  DATA_W  write data
- dc_req_wmask  in  DATA_W/8  byte enables for writes
- dc_resp_valid  out  1  one-cycle pulse: read data valid, or write complete
- dc_resp_data  out  DATA_W  dcache read data (0 for writes)
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepted the request
- mem_req_rw  out  1  1 = write
- mem_req_addr  out  ADDR_W  memory address
- mem_req_wdata  out  DATA_W  memory write data
- mem_req_wmask  out  DATA_W/8  memory byte enables
- mem_resp_valid  in  1  read response valid
- mem_resp_data  in  DATA_W  read response data
- busy  out  1  state != IDLE

Behaviour:
- One clock; reset is asynchronous and active-low.
- reset_n low, immediately and regardless of clk:
  - state = IDLE; owner = NONE; starve count = 0.
  - All valid/ready outputs 0; all data/addr registers 0; busy 0.
- Reset mid-transaction abandons the transaction. The memory is reset by the same signal.
- FSM states: IDLE, REQ, WAIT_RESP, RESP.
- IDLE:
  - ic_req_ready/dc_req_ready are combinational, asserted only for the arbitration winner.
  - Winner: dc if dc_req_valid and not (ic_req_valid and starve == STARVE_LIMIT); else ic if ic_req_valid.
  - On the handshake: latch addr, rw, wdata and wmask (icache: rw = 0, wmask = 0), record the owner, go to REQ.
- REQ:
  - mem_req_valid = 1 with the latched fields held stable.
  - On mem_req_ready: a read goes to WAIT_RESP; a write goes to RESP.
- WAIT_RESP:
  - On mem_resp_valid, latch mem_resp_data and go to RESP.
  - mem_resp_valid in any other state is ignored.
- RESP:
  - The owner's resp_valid = 1 for exactly one cycle, with the latched data (0 for writes). The other requester's resp_valid stays 0.
  - Next state is IDLE. Readys are 0 in this state.
- Minimum occupancy:
  - Read with mem_req_ready and mem_resp_valid each on their first eligible cycle: 4 cycles from accept to the next possible accept. The resp pulse is on cycle 3, where the accept cycle is cycle 0.
  - Write: 3 cycles.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) when dc is granted while ic_req_valid = 1.
  - Clears when ic is granted, or when in IDLE with ic_req_valid = 0.
- Requesters must hold valid and the request fields stable until ready. Deasserting valid before ready is legal and means no grant.
- dcache priority also applies when the icache was already waiting.

Optional Feature:
- Macro: CACHE_MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_ic_grants[31:0], perf_dc_grants[31:0] and perf_wait_cycles[31:0].
  - perf_wait_cycles counts cycles with any req_valid high but no handshake.
  - Counters are wrapping and reset to 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cache_arb_pkg holds:
  - the state encoding (IDLE = 0, REQ = 1, WAIT_RESP = 2, RESP = 3)
  - owner IDs (OWN_NONE = 0, OWN_IC = 1, OWN_DC = 2)
  - the RW_READ/RW_WRITE constants
- One sub-module is natural: arb_starve_counter. It contains the saturating counter plus the force-ic compare, parameterised by STARVE_LIMIT.

Test Plan:
- Lone icache read, addr 0x100: mem accepts the next cycle and responds 2 cycles later with 0xA5..A5. Expect:
  - mem_req_addr = 0x100
  - ic_resp_valid pulse, one cycle after mem_resp_valid, data 0xA5..A5
  - dc_resp_valid stays 0
- dcache write, addr 0x200, wmask 0x000F, data 0x1234: expect mem_req_rw = 1 with the mask/data unchanged, then a dc_resp_valid pulse with data 0 the cycle after the mem handshake.
- Both requesters held valid continuously, STARVE_LIMIT = 4: expect a grant order of dc, dc, dc, dc, ic, dc, ...
- mem_req_ready held low 5 cycles in REQ: expect mem_req_valid and the fields stable for all 5 cycles, and no resp pulses.
- Spurious mem_resp_valid in IDLE: expect no resp pulse and state stays IDLE.
- reset_n asserted during WAIT_RESP, then released: expect all outputs 0 asynchronously, busy 0, and the next ic request served normally.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// ---------------------------------------------------------------------------
// cache_arb_pkg
// Shared definitions for the icache/dcache backing-memory arbiter:
//   - arb_state_e : FSM encoding (IDLE=0, REQ=1, WAIT_RESP=2, RESP=3)
//   - owner_e     : which requester owns the in-flight transaction
//   - RW_READ / RW_WRITE : memory request direction
//   - STARVE_CNT_W : width of the anti-starvation counter (limit 1..15)
// ---------------------------------------------------------------------------
package cache_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2,
        RESP      = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IC   = 2'd1,
        OWN_DC   = 2'd2
    } owner_e;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam int STARVE_CNT_W = 4;

endpackage : cache_arb_pkg

// File: rtl/arb_starve_counter.sv
// ---------------------------------------------------------------------------
// arb_starve_counter
// Counts consecutive dcache grants taken while the icache was waiting and
// raises force_ic_o once that count reaches STARVE_LIMIT, so the icache wins
// the next arbitration.
// Ports:
//   clk          - clock
//   rst_n_i      - asynchronous active-low reset
//   in_idle_i    - arbiter is in IDLE (arbitration cycle)
//   ic_waiting_i - icache request valid
//   grant_ic_i   - icache handshake this cycle
//   grant_dc_i   - dcache handshake this cycle
//   force_ic_o   - icache must win the next arbitration it takes part in
// ---------------------------------------------------------------------------
module arb_starve_counter
    import cache_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n_i,
    input  logic in_idle_i,
    input  logic ic_waiting_i,
    input  logic grant_ic_i,
    input  logic grant_dc_i,
    output logic force_ic_o
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (grant_ic_i) begin
            cnt_d = '0;
        end else if (grant_dc_i && ic_waiting_i) begin
            // Saturate so a long dcache burst cannot wrap the count back to 0.
            cnt_d = (cnt_q == LIMIT) ? LIMIT : cnt_q + 1'b1;
        end else if (in_idle_i && !ic_waiting_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_ic_o = (cnt_q == LIMIT);

endmodule : arb_starve_counter

// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter
// Shares one backing-memory port between the icache refill path (reads only)
// and the dcache refill/writeback path. One memory transaction in flight at a
// time; dcache has priority, bounded by an anti-starvation counter for icache.
//
// Ports:
//   clk, reset_n                 - clock, asynchronous active-low reset
//   ic_req_*  / ic_resp_*        - icache valid/ready request, 1-cycle response
//   dc_req_*  / dc_resp_*        - dcache valid/ready request (rw/wdata/wmask),
//                                  1-cycle response (data 0 for writes)
//   mem_req_* / mem_resp_*       - memory valid/ready request, read response
//   busy                         - FSM not in IDLE
// Optional feature (macro CACHE_MEM_ARB_PERF_EN):
//   perf_ic_grants, perf_dc_grants, perf_wait_cycles - wrapping 32-bit
//   counters of grants and of cycles with a request pending but no handshake.
// ---------------------------------------------------------------------------
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ic_req_valid,
    output logic                ic_req_ready,
    input  logic [ADDR_W-1:0]   ic_req_addr,
    output logic                ic_resp_valid,
    output logic [DATA_W-1:0]   ic_resp_data,
    input  logic                dc_req_valid,
    output logic                dc_req_ready,
    input  logic                dc_req_rw,
    input  logic [ADDR_W-1:0]   dc_req_addr,
    input  logic [DATA_W-1:0]   dc_req_wdata,
    input  logic [DATA_W/8-1:0] dc_req_wmask,
    output logic                dc_resp_valid,
    output logic [DATA_W-1:0]   dc_resp_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_rw,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data,
    output logic                busy
`ifdef CACHE_MEM_ARB_PERF_EN
    ,
    output logic [31:0]         perf_ic_grants,
    output logic [31:0]         perf_dc_grants,
    output logic [31:0]         perf_wait_cycles
`endif
);

    arb_state_e            state_q, state_d;
    owner_e                owner_q, owner_d;
    logic                  rw_q, rw_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wmask_q, wmask_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;

    logic in_idle;
    logic force_ic;
    logic grant_dc;
    logic grant_ic;

    assign in_idle = (state_q == IDLE);

    // Readys are gated by reset_n so they drop immediately on an asynchronous
    // reset even while a requester keeps valid high.
    assign grant_dc = in_idle && reset_n && dc_req_valid &&
                      !(ic_req_valid && force_ic);
    assign grant_ic = in_idle && reset_n && ic_req_valid && !grant_dc;

    assign dc_req_ready = grant_dc;
    assign ic_req_ready = grant_ic;

    arb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk          (clk),
        .rst_n_i      (reset_n),
        .in_idle_i    (in_idle),
        .ic_waiting_i (ic_req_valid),
        .grant_ic_i   (grant_ic),
        .grant_dc_i   (grant_dc),
        .force_ic_o   (force_ic)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_dc) begin
                    owner_d = OWN_DC;
                    rw_d    = dc_req_rw;
                    addr_d  = dc_req_addr;
                    wdata_d = dc_req_wdata;
                    wmask_d = dc_req_wmask;
                    rdata_d = '0;   // writes report zero data
                    state_d = REQ;
                end else if (grant_ic) begin
                    owner_d = OWN_IC;
                    rw_d    = RW_READ;
                    addr_d  = ic_req_addr;
                    wdata_d = '0;
                    wmask_d = '0;
                    rdata_d = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = (rw_q == RW_WRITE) ? RESP : WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (mem_resp_valid) begin
                    rdata_d = mem_resp_data;
                    state_d = RESP;
                end
            end
            RESP: begin
                owner_d = OWN_NONE;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
            rw_q    <= RW_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_req_valid = (state_q == REQ);
    assign mem_req_rw    = rw_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;

    assign ic_resp_valid = (state_q == RESP) && (owner_q == OWN_IC);
    assign dc_resp_valid = (state_q == RESP) && (owner_q == OWN_DC);
    assign ic_resp_data  = ic_resp_valid ? rdata_q : '0;
    assign dc_resp_data  = dc_resp_valid ? rdata_q : '0;

    assign busy = !in_idle;

`ifdef CACHE_MEM_ARB_PERF_EN
    logic [31:0] perf_ic_q;
    logic [31:0] perf_dc_q;
    logic [31:0] perf_wait_q;
    logic        wait_cycle;

    assign wait_cycle = (ic_req_valid || dc_req_valid) && !(grant_ic || grant_dc);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_ic_q   <= '0;
            perf_dc_q   <= '0;
            perf_wait_q <= '0;
        end else begin
            perf_ic_q   <= perf_ic_q + 32'(grant_ic);
            perf_dc_q   <= perf_dc_q + 32'(grant_dc);
            perf_wait_q <= perf_wait_q + 32'(wait_cycle);
        end
    end

    assign perf_ic_grants   = perf_ic_q;
    assign perf_dc_grants   = perf_dc_q;
    assign perf_wait_cycles = perf_wait_q;
`endif

endmodule : cache_mem_arbiter
